imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. The datapath's fetch stage only reads that memory; this block fills it from a host word stream over a valid/ready handshake.
- Asserts cpu_hold to freeze the PC and pipeline while loading.
- Checks the stream against a trailing checksum word, then releases the CPU.
- Sits beside InstructionMemory (drives its write port) and PC (drives its hold input).

Parameters:
ADDR_W, 8, instruction memory address width in words
DEPTH, 256, instruction memory depth in words (must be <= 2^ADDR_W)
BASE, 0, first word address written

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle pulse requesting a new load
word_count  input  ADDR_W+1  number of program words, sampled on accepted start
in_valid  input  1  host word valid
in_data  input  32  host word (program words, then one checksum word)
in_ready  output  1  loader accepts in_data this cycle
im_wr_en  output  1  instruction memory write strobe
im_wr_addr  output  ADDR_W  instruction memory write address
im_wr_data  output  32  instruction memory write data
cpu_hold  output  1  freeze PC/pipeline
load_done  output  1  sticky: last load passed checksum
load_error  output  1  sticky: last load/start failed
checksum  output  32  running sum of accepted program words
words_written  output  ADDR_W+1  program words written so far

Behaviour:
- Synchronous active-low reset. All outputs reset to 0 and state goes to IDLE. Reset mid-load aborts at the next edge, with no further write strobes.
- States: IDLE, LOAD, CHECK, DONE, FAIL.
- IDLE:
  - in_ready=0.
  - On start with 1 <= word_count <= DEPTH: latch the count, clear checksum, words_written, load_done and load_error, set cpu_hold=1, go to LOAD.
  - On start with word_count==0 or >DEPTH: load_error=1, cpu_hold unchanged, stay IDLE.
- LOAD:
  - in_ready=1.
  - Handshake = in_valid & in_ready. Each handshake adds in_data to checksum (mod 2^32) and increments words_written.
  - Write strobe comes one cycle after the handshake: im_wr_en=1, im_wr_data = the word, im_wr_addr = (BASE + index) mod DEPTH, where index starts at 0.
  - im_wr_en is low in any cycle with no pending write. Back-to-back handshakes give back-to-back writes.
  - The handshake of word word_count-1 moves to CHECK.
- CHECK:
  - in_ready=1. im_wr_en never asserts for the checksum word.
  - On handshake, compare in_data to checksum. Equal -> DONE, else -> FAIL.
- DONE: load_done=1, cpu_hold=0 (deasserts the cycle after the checksum handshake), in_ready=0. Behaves as IDLE for start.
- FAIL: load_error=1, cpu_hold stays 1, in_ready=0. Behaves as IDLE for start; a valid start clears load_error.
- start is ignored in LOAD and CHECK.
- The last program write and the CHECK handshake may occur in the same cycle.
- Address wrap: with BASE near DEPTH, addresses wrap modulo DEPTH; there is no error for wrapping.
- in_valid with in_ready=0 is ignored; no word is consumed.

Test Plan:
- Reset, start with word_count=3. Send 0x10000001, 0x20000002, 0x30000003, then trailer 0x60000006 -> writes at addr 0,1,2 each one cycle after handshake; checksum=0x60000006; load_done=1; cpu_hold goes 1 -> 0 the cycle after the trailer.
- Same stream with trailer 0x60000007 -> load_error=1, load_done=0, cpu_hold stays 1. A new valid start clears load_error.
- start with word_count=0, then word_count=DEPTH+1 -> load_error=1, state IDLE, in_ready=0, no writes.
- in_valid toggling every other cycle across 4 words -> exactly 4 im_wr_en pulses at addr 0..3 with no duplicates. Words offered in cycles where in_ready=0 are not consumed.
- BASE=254, DEPTH=256, word_count=4 -> addresses 254, 255, 0, 1.
- rst_n low after 2 of 5 words accepted -> next cycle: im_wr_en=0, cpu_hold=0, words_written=0, in_ready=0. A subsequent start reloads cleanly from BASE.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Fills instruction memory from a host valid/ready word stream,
//            holds the CPU while loading and verifies a trailing checksum.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [31:0]       im_wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [31:0]       checksum,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE % DEPTH);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_one       = (ADDR_W + 1)'(1);

    state_t              r_state;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_in_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_hold;
    logic                r_done;
    logic                r_error;
    logic [31:0]         r_sum;
    logic [ADDR_W:0]     r_written;

    logic                w_hs;
    logic                w_start_ok;
    logic [ADDR_W:0]     w_written_next;
    logic [ADDR_W-1:0]   w_addr_next;

    assign w_hs           = in_valid & r_in_ready;
    assign w_start_ok     = (word_count != '0) && (word_count <= c_depth);
    assign w_written_next = r_written + c_one;
    // Address counter wraps at DEPTH, which need not be a power of two
    assign w_addr_next    = (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_addr     <= '0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_sum      <= '0;
            r_written  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_state    <= S_LOAD;
                            r_count    <= word_count;
                            r_addr     <= c_base_addr;
                            r_sum      <= '0;
                            r_written  <= '0;
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_hold     <= 1'b1;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_sum     <= r_sum + in_data;
                        r_written <= w_written_next;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= in_data;
                        r_addr    <= w_addr_next;
                        if (w_written_next == r_count) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    // r_sum already includes the final program word here
                    if (w_hs) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_sum) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= S_FAIL;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign im_wr_en      = r_wr_en;
    assign im_wr_addr    = r_wr_addr;
    assign im_wr_data    = r_wr_data;
    assign cpu_hold      = r_hold;
    assign load_done     = r_done;
    assign load_error    = r_error;
    assign checksum      = r_sum;
    assign words_written = r_written;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// Directed self-checking bench for imem_loader (default instance plus a
// BASE=254 instance for address wrap).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        im_wr_en;
    logic [7:0]  im_wr_addr;
    logic [31:0] im_wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [31:0] checksum;
    logic [8:0]  words_written;

    logic        w_start;
    logic [8:0]  w_word_count;
    logic        w_in_valid;
    logic [31:0] w_in_data;
    logic        w_in_ready;
    logic        w_im_wr_en;
    logic [7:0]  w_im_wr_addr;
    logic [31:0] w_im_wr_data;
    logic        w_cpu_hold;
    logic        w_load_done;
    logic        w_load_error;
    logic [31:0] w_checksum;
    logic [8:0]  w_words_written;

    int total = 0;
    int bad   = 0;
    int pulses;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .DEPTH(256), .BASE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
        .checksum(checksum), .words_written(words_written)
    );

    imem_loader #(.ADDR_W(8), .DEPTH(256), .BASE(254)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(w_start), .word_count(w_word_count),
        .in_valid(w_in_valid), .in_data(w_in_data), .in_ready(w_in_ready),
        .im_wr_en(w_im_wr_en), .im_wr_addr(w_im_wr_addr), .im_wr_data(w_im_wr_data),
        .cpu_hold(w_cpu_hold), .load_done(w_load_done), .load_error(w_load_error),
        .checksum(w_checksum), .words_written(w_words_written)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
        w_start = 1'b0; w_word_count = '0; w_in_valid = 1'b0; w_in_data = '0;
        tick(); tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        chk("rst_wr_en", im_wr_en, 0);
        chk("rst_written", words_written, 0);
        chk("rst_sum", checksum, 0);

        // Invalid starts from IDLE
        rst_n = 1'b1;
        start = 1'b1; word_count = 9'd0;
        tick();
        chk("bad0_err", load_error, 1);
        chk("bad0_ready", in_ready, 0);
        chk("bad0_hold", cpu_hold, 0);
        chk("bad0_wr", im_wr_en, 0);
        word_count = 9'd257;
        tick();
        chk("bad257_err", load_error, 1);
        chk("bad257_ready", in_ready, 0);
        chk("bad257_wr", im_wr_en, 0);
        start = 1'b0;
        tick();
        chk("bad_idle_ready", in_ready, 0);

        // Good load of three words
        start = 1'b1; word_count = 9'd3;
        tick();
        start = 1'b0;
        chk("ld1_hold", cpu_hold, 1);
        chk("ld1_ready", in_ready, 1);
        chk("ld1_err_clr", load_error, 0);
        chk("ld1_no_wr", im_wr_en, 0);
        in_valid = 1'b1; in_data = 32'h1000_0001;
        tick();
        chk("ld1_w0_en", im_wr_en, 1);
        chk("ld1_w0_addr", im_wr_addr, 0);
        chk("ld1_w0_data", im_wr_data, 32'h1000_0001);
        in_data = 32'h2000_0002;
        tick();
        chk("ld1_w1_en", im_wr_en, 1);
        chk("ld1_w1_addr", im_wr_addr, 1);
        chk("ld1_w1_data", im_wr_data, 32'h2000_0002);
        in_data = 32'h3000_0003;
        tick();
        chk("ld1_w2_en", im_wr_en, 1);
        chk("ld1_w2_addr", im_wr_addr, 2);
        chk("ld1_w2_data", im_wr_data, 32'h3000_0003);
        chk("ld1_sum", checksum, 32'h6000_0006);
        chk("ld1_written", words_written, 3);
        chk("ld1_chk_ready", in_ready, 1);
        chk("ld1_chk_hold", cpu_hold, 1);
        in_data = 32'h6000_0006;
        tick();
        in_valid = 1'b0;
        chk("ld1_trl_no_wr", im_wr_en, 0);
        chk("ld1_done", load_done, 1);
        chk("ld1_hold_rel", cpu_hold, 0);
        chk("ld1_ready_off", in_ready, 0);
        chk("ld1_err", load_error, 0);

        // Same stream with a bad trailer
        start = 1'b1; word_count = 9'd3;
        tick();
        start = 1'b0;
        chk("ld2_done_clr", load_done, 0);
        in_valid = 1'b1; in_data = 32'h1000_0001;
        tick();
        in_data = 32'h2000_0002;
        tick();
        in_data = 32'h3000_0003;
        tick();
        in_data = 32'h6000_0007;
        tick();
        in_valid = 1'b0;
        chk("ld2_err", load_error, 1);
        chk("ld2_done", load_done, 0);
        chk("ld2_hold", cpu_hold, 1);
        chk("ld2_ready", in_ready, 0);
        chk("ld2_no_wr", im_wr_en, 0);
        tick();
        chk("ld2_hold_stay", cpu_hold, 1);

        // Valid start clears the error; in_valid toggles across four words
        start = 1'b1; word_count = 9'd4;
        tick();
        start = 1'b0;
        chk("ld3_err_clr", load_error, 0);
        chk("ld3_hold", cpu_hold, 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 32'h0000_00A0 + i;
            tick();
            if (im_wr_en) begin
                chk("ld3_addr", im_wr_addr, pulses);
                chk("ld3_data", im_wr_data, 32'h0000_00A0 + 2 * pulses);
                pulses++;
            end
        end
        in_valid = 1'b0;
        tick();
        if (im_wr_en) pulses++;
        chk("ld3_pulses", pulses, 4);
        chk("ld3_written", words_written, 4);
        chk("ld3_sum", checksum, 32'h0000_028C);
        in_valid = 1'b1; in_data = 32'h0000_028C;
        tick();
        chk("ld3_done", load_done, 1);
        chk("ld3_hold_rel", cpu_hold, 0);
        // Words offered while in_ready is low are not consumed
        in_data = 32'hDEAD_BEEF;
        tick();
        chk("ld3_ign_wr", im_wr_en, 0);
        tick();
        chk("ld3_ign_written", words_written, 4);
        chk("ld3_ign_sum", checksum, 32'h0000_028C);
        in_valid = 1'b0;

        // Reset after two of five words
        start = 1'b1; word_count = 9'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0011;
        tick();
        in_data = 32'h0000_0022;
        tick();
        chk("rst_mid_written", words_written, 2);
        chk("rst_mid_wr1", im_wr_en, 1);
        rst_n = 1'b0; in_data = 32'h0000_0033;
        tick();
        chk("rst_mid_wr_en", im_wr_en, 0);
        chk("rst_mid_hold", cpu_hold, 0);
        chk("rst_mid_written0", words_written, 0);
        chk("rst_mid_ready", in_ready, 0);
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
        start = 1'b1; word_count = 9'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0055;
        tick();
        chk("reload_en", im_wr_en, 1);
        chk("reload_addr", im_wr_addr, 0);
        chk("reload_data", im_wr_data, 32'h0000_0055);
        tick();
        in_valid = 1'b0;
        chk("reload_done", load_done, 1);
        chk("reload_hold", cpu_hold, 0);

        // Address wrap with BASE=254
        w_start = 1'b1; w_word_count = 9'd4;
        tick();
        w_start = 1'b0;
        w_in_valid = 1'b1; w_in_data = 32'd1;
        tick();
        chk("wrap_a0", w_im_wr_addr, 254);
        chk("wrap_e0", w_im_wr_en, 1);
        w_in_data = 32'd2;
        tick();
        chk("wrap_a1", w_im_wr_addr, 255);
        w_in_data = 32'd3;
        tick();
        chk("wrap_a2", w_im_wr_addr, 0);
        chk("wrap_d2", w_im_wr_data, 3);
        w_in_data = 32'd4;
        tick();
        chk("wrap_a3", w_im_wr_addr, 1);
        chk("wrap_e3", w_im_wr_en, 1);
        w_in_data = 32'd10;
        tick();
        w_in_valid = 1'b0;
        chk("wrap_done", w_load_done, 1);
        chk("wrap_err", w_load_error, 0);
        chk("wrap_no_wr", w_im_wr_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
